// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   XLEN       data/address width (the fetch entry struct uses it, so it is
//              set here rather than per instance)
//   NOP_INSTR  instruction shown on if_instr while the queue is empty
//   fetch_entry_t  {pc, instr} pair held in the prefetch queue
//   cnt_w()    width of a counter that must hold 0..depth inclusive
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory port, the MEM-stage redirect and
// the IF/ID handshake of the fetch unit.
//   master: the fetch unit (drives imem_req/imem_addr and if_*)
//   slave : the surrounding pipeline and instruction memory
// Handshake semantics: a request transfers on a cycle where imem_req and
// imem_ready are both 1; an instruction transfers to IF/ID on a cycle where
// if_valid and id_ready are both 1. imem_rvalid is a one-cycle pulse per
// response, responses in request order. redirect_valid is a one-cycle
// command that overrides everything else in that cycle.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue of fetch_entry_t, DEPTH entries (power of two).
//   clk, rst  clock, asynchronous active-high reset
//   i_push    write i_data at the tail (ignored when full or flushing)
//   i_pop     drop the head entry (ignored when empty or flushing)
//   i_flush   empty the queue; wins over push and pop
//   o_head    head entry (undefined while o_empty)
//   o_count   number of stored entries, o_empty = (o_count == 0)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_head,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_empty
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !i_flush && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, issues word-address
// requests, buffers in-order responses in a prefetch queue and hands
// {pc, instr} to IF/ID. A MEM-stage redirect flushes the queue and arranges
// for responses still in flight to be discarded.
//   clk, rst  clock, asynchronous active-high reset
//   bus       fetch_if.master (imem_*, redirect_*, if_*, id_ready)
//   Optional (macro FETCH_PERF_EN): perf_stall_cycles, perf_flushes,
//   saturating 32-bit event counters.
// Parameters: DEPTH (queue entries and in-flight credit cap), RESET_PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
`endif
);

  localparam int CW = cnt_w(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [XLEN-1:0] r_pc_hold;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_inflight;
  logic            w_empty;
  logic            w_req;
  logic            w_accept;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_redir;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  assign w_redir = bus.redirect_valid;

  // Credit rule: queued + outstanding never exceeds DEPTH, so every
  // response always has a free queue slot.
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_req      = !rst && (w_inflight < (CW+1)'(DEPTH)) && !w_redir;
  assign w_accept   = w_req && bus.imem_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp     = bus.imem_rvalid && (r_outstanding != '0);
  assign w_push     = w_resp && (r_drop_cnt == '0) && !w_redir;
  assign w_pop      = !w_empty && bus.id_ready && !w_redir;

  assign w_push_data.pc    = r_resp_pc;
  assign w_push_data.instr = bus.imem_rdata;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_pc_hold     <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_resp);
      if (!w_empty) r_pc_hold <= w_head.pc;
      if (w_redir) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_drop_cnt <= r_outstanding - CW'(w_resp);
        r_fetch_pc <= bus.redirect_pc;
        r_resp_pc  <= bus.redirect_pc;
      end else begin
        if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(1);
        if (w_push)   r_resp_pc  <= r_resp_pc + XLEN'(1);
      end
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.if_valid  = !w_empty;
  assign bus.if_pc     = w_empty ? r_pc_hold : w_head.pc;
  assign bus.if_instr  = w_empty ? NOP_INSTR : w_head.instr;

  a_no_orphan_rvalid: assert property (
    @(posedge clk) disable iff (rst) !(bus.imem_rvalid && (r_outstanding == '0))
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (!w_empty && !bus.id_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_redir && (r_perf_flush != '1))
        r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flushes      = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a transaction-level
// reference model (queues of visible instructions plus in-flight bookkeeping)
// and an in-order instruction memory that answers addr with addr+0x100.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'd0;
  localparam logic [31:0] NOP    = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  logic [31:0] exp_q[$];        // PCs expected at IF/ID, oldest first
  logic [31:0] exp_instr_q[$];
  logic [31:0] m_fetch_pc, m_resp_pc, m_last_pc, next_pop;
  int          m_out, m_drop, m_stall, m_flush;

  logic        obs_req, obs_valid, popped;
  logic [31:0] obs_pc, obs_instr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); exp_instr_q.delete();
    mem_addr_q.delete(); mem_due_q.delete();
    m_fetch_pc = RST_PC; m_resp_pc = RST_PC; m_last_pc = 32'd0;
    next_pop = RST_PC; m_out = 0; m_drop = 0; m_stall = 0; m_flush = 0;
  endtask

  // Asserts reset wherever the caller is in the cycle and checks the outputs
  // respond without waiting for a clock edge.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    #1;
    check("rst_imem_req",  32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, RST_PC);
    check("rst_if_valid",  32'(bus.if_valid), 32'd0);
    check("rst_if_pc",     bus.if_pc, 32'd0);
    check("rst_if_instr",  bus.if_instr, NOP);
    model_reset();
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic redir, input logic [31:0] tgt,
                       input logic rdy, input logic idr);
    logic rv, exp_req, exp_valid;
    @(negedge clk);
    cyc++;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.imem_ready     = rdy;
    bus.id_ready       = idr;
    rv = (mem_due_q.size() != 0) && (mem_due_q[0] <= cyc);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_addr_q[0] + 32'h100 : 32'hdeadbeef;
    #1;
    obs_req = bus.imem_req; obs_valid = bus.if_valid;
    obs_pc  = bus.if_pc;    obs_instr = bus.if_instr;

    exp_valid = (exp_q.size() != 0);
    exp_req   = ((exp_q.size() + m_out) < DEPTH) && !redir;
    check("imem_req",  32'(obs_req), 32'(exp_req));
    check("imem_addr", bus.imem_addr, m_fetch_pc);
    check("if_valid",  32'(obs_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("if_pc", obs_pc, exp_q[0]);
      check("if_instr", obs_instr, exp_instr_q[0]);
      m_last_pc = exp_q[0];
    end else begin
      check("if_pc_hold", obs_pc, m_last_pc);
      check("if_instr_nop", obs_instr, NOP);
    end

    // Sequence view of what IF/ID actually takes.
    popped = obs_valid && idr && !redir;
    if (popped) begin
      check("pop_seq", obs_pc, next_pop);
      check("pop_instr", obs_instr, obs_pc + 32'h100);
      next_pop = obs_pc + 32'd1;
    end

    // Memory environment.
    if (rv) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (obs_req && rdy) begin
      mem_addr_q.push_back(bus.imem_addr);
      mem_due_q.push_back(cyc + lat);
    end

    // Reference model update.
    if (exp_valid && !idr) m_stall++;
    if (redir) begin
      m_flush++;
      exp_q.delete(); exp_instr_q.delete();
      m_out  = m_out - (rv ? 1 : 0);
      m_drop = m_out;
      m_fetch_pc = tgt; m_resp_pc = tgt; next_pop = tgt;
    end else begin
      if (exp_valid && idr) begin
        void'(exp_q.pop_front());
        void'(exp_instr_q.pop_front());
      end
      if (exp_req && rdy) begin
        m_fetch_pc++;
        m_out++;
      end
      if (rv) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin
          exp_q.push_back(m_resp_pc);
          exp_instr_q.push_back(m_resp_pc + 32'h100);
          m_resp_pc++;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int          first_req, first_vld, n_pop, t5_pops;
  logic [31:0] pop_pc[3];
  logic [31:0] pop_in[3];
  logic        seen;

  initial begin
    do_reset(2);

    // Sequential fetch with a zero-wait memory.
    lat = 1; first_req = -1; first_vld = -1; n_pop = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      if (first_req < 0 && obs_req) first_req = cyc;
      if (first_vld < 0 && obs_valid) first_vld = cyc;
      if (popped && n_pop < 3) begin
        pop_pc[n_pop] = obs_pc; pop_in[n_pop] = obs_instr; n_pop++;
      end
    end
    check("first_valid_latency", 32'(first_vld - first_req), 32'd2);
    for (int k = 0; k < 3; k++) begin
      check("t1_pc", pop_pc[k], 32'(k));
      check("t1_instr", pop_in[k], 32'h100 + 32'(k));
    end

    // IF/ID stalled for 10 cycles: queue fills, requests stop.
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("stall_valid", 32'(obs_valid), 32'd1);
    check("stall_req", 32'(obs_req), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);

    // Slow memory, redirect with requests in flight.
    lat = 4;
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h40, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      if (obs_valid) begin
        seen = 1'b1;
        check("redir_pc", obs_pc, 32'h40);
        check("redir_instr", obs_instr, 32'h140);
      end
    end
    check("redir_seen", 32'(seen), 32'd1);

    // Redirect coinciding with a response and a pop, two entries queued.
    lat = 1;
    for (int i = 0; i < 10 && exp_q.size() < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'h80, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("flush_empty", 32'(obs_valid), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1);

    // Toggling memory ready, random IF/ID stalls, 200 instructions.
    t5_pops = 0;
    for (int i = 0; i < 3000 && t5_pops < 200; i++) begin
      cycle(1'b0, '0, 1'(i % 2 == 0), 1'($urandom_range(0, 1)));
      if (popped) t5_pops++;
    end
    check("t5_200_pops", 32'(t5_pops >= 200), 32'd1);

    // Random redirects, latencies and targets (including PC wrap).
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic [31:0] t;
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      r = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 3) == 0) ? 32'hfffffffe : $urandom();
      cycle(r, t, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

`ifdef FETCH_PERF_EN
    check("perf_stall", perf_stall_cycles, 32'(m_stall));
    check("perf_flush", perf_flushes, 32'(m_flush));
`endif

    // Reset mid-stream with requests outstanding.
    cycle(1'b1, 32'h200, 1'b0, 1'b1);
    lat = 3;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    #2;
    do_reset(2);
    lat = 1;
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    check("restart_next_pc", next_pop, RST_PC + 32'(n_pop_after_restart()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // PCs consumed since the restart, counted from the model's own queue
  // bookkeeping: everything fetched minus what is still queued or in flight.
  function automatic int n_pop_after_restart();
    return int'(m_fetch_pc - RST_PC) - exp_q.size() - m_out;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the program counter and issues word-addressed requests to the instruction memory.
- Buffers returned instructions in a small prefetch queue and presents {pc, instr} to the IF/ID pipeline register with a valid/ready handshake.
- Accepts the taken-branch redirect from the MEM stage. Flushes queued and in-flight instructions on a redirect.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, prefetch queue entries; also the cap on queued + outstanding requests (power of two, ≥2).
- RESET_PC, 32'd0, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  word address of the request.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in order.
- imem_rdata  in  XLEN  instruction word.
- redirect_valid  in  1  taken branch from MEM stage.
- redirect_pc  in  XLEN  branch target (word address).
- if_valid  out  1  head entry valid toward IF/ID.
- if_pc  out  XLEN  PC of head instruction.
- if_instr  out  XLEN  head instruction.
- id_ready  in  1  IF/ID accepts the head this cycle (0 = stall).

Behaviour:
- Reset (async, on rst=1 at any time, including mid-burst):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC; queue count=0; outstanding=0; drop_cnt=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP (32'h00000013).
- Request issue:
  - imem_req=1 when (count + outstanding) < DEPTH and redirect_valid=0.
  - imem_addr=fetch_pc.
  - Request accepted when imem_req && imem_ready: fetch_pc += 1 (word step, wraps modulo 2^XLEN), outstanding += 1.
- Response:
  - imem_rvalid while drop_cnt>0: data discarded, drop_cnt -= 1, outstanding -= 1.
  - Otherwise: push {resp_pc, imem_rdata}, resp_pc += 1, outstanding -= 1.
  - Earliest visibility at if_* is the cycle after rvalid (registered queue, no bypass).
  - imem_rvalid with outstanding=0 is a protocol error: ignored, flagged by an assertion.
- Output:
  - if_valid = (count != 0); if_pc/if_instr come from the head entry.
  - Pop when if_valid && id_ready.
  - When empty: if_pc holds its last value; if_instr=NOP.
- Simultaneous events:
  - Push, pop and request acceptance can all occur in one cycle; counters update by the net change.
  - The credit rule (count+outstanding ≤ DEPTH) guarantees the queue never overflows, even with push at count=DEPTH-1 and no pop.
- Redirect (redirect_valid=1), highest priority:
  - Queue flushed (count=0); pop ignored; no request issued that cycle.
  - drop_cnt <= outstanding − imem_rvalid; any response in the same cycle is discarded.
  - fetch_pc <= redirect_pc, resp_pc <= redirect_pc.
  - A first request to redirect_pc is issued the next cycle.
  - Back-to-back redirects: the last one wins; drop accounting applies each cycle.
- Latency:
  - Redirect to imem_req at target: 1 cycle.
  - Zero-wait memory (ready=1, rvalid the cycle after accept): first if_valid 2 cycles after the request.
  - Steady-state throughput: 1 instr/cycle.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_stall_cycles[31:0] (cycles with if_valid=1 && id_ready=0) and perf_flushes[31:0] (redirect count).
  - Both are saturating, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - XLEN default, NOP_INSTR=32'h00000013.
  - fetch_entry_t struct {pc, instr}.
  - Counter-width helper (clog2(DEPTH+1)).
- One sub-module, fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push/pop/flush, count and empty outputs.
  - Asynchronous reset.

Test Plan:
- Reset then ready=1, 1-cycle rvalid returning addr+0x100 → requests addrs 0,1,2,…; if_pc 0,1,2 with if_instr 0x100,0x101,0x102 consecutively; first if_valid 2 cycles after first request.
- id_ready=0 for 10 cycles → at most DEPTH=4 entries queued plus 0 outstanding; imem_req=0 once credits are exhausted; no entry lost after release, order preserved.
- Three requests outstanding (rvalid delayed 3 cycles), redirect_pc=0x40 → those 3 responses dropped; next if_pc=0x40, if_instr=mem[0x40].
- Redirect in the same cycle as rvalid and a pop with 2 queued → queue empty next cycle, drop_cnt=outstanding−1, no stale PC ever appears at if_pc.
- imem_ready toggling 1/0 every cycle with id_ready random → if_pc strictly sequential, no duplicates or gaps over 200 instructions.
- rst asserted mid-stream with 2 outstanding → outputs return to reset values immediately (async); after release, fetch restarts at RESET_PC=0.
